// File: rtl/id_ex_ctrl_reg_pkg.sv
// Shared pipeline parameters for the ID/EX and EX/MEM registers.
// Holds the control encodings, the bubble constants and the ID/EX bundle type.
package id_ex_ctrl_reg_pkg;

    // RegWrite encodings (load width / write enable)
    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    // BranchType encodings
    localparam logic [2:0] NOBRANCH   = 3'd0;
    localparam logic [2:0] BEQ        = 3'd1;
    localparam logic [2:0] BNE        = 3'd2;
    localparam logic [2:0] BLT        = 3'd3;
    localparam logic [2:0] BLTU       = 3'd4;
    localparam logic [2:0] BGE        = 3'd5;
    localparam logic [2:0] BGEU       = 3'd6;

    // ALU control encodings
    localparam logic [3:0] ALU_ADD    = 4'd3;
    localparam logic [3:0] ALU_SUB    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd0;
    localparam logic [3:0] ALU_SRL    = 4'd1;
    localparam logic [3:0] ALU_SRA    = 4'd2;

    // Bubble constants, also used by the EX/MEM register
    localparam logic [3:0] MEMWRITE_NONE  = 4'b0000;
    localparam logic [1:0] ALUSRC2_BUBBLE = 2'b00;

    typedef struct packed {
        logic        jalr;
        logic [2:0]  reg_write;
        logic        mem_to_reg;
        logic [3:0]  mem_write;
        logic        load_npc;
        logic [1:0]  reg_read;
        logic [2:0]  branch_type;
        logic [3:0]  alu_contrl;
        logic        alu_src1;
        logic [1:0]  alu_src2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] reg_out1;
        logic [31:0] reg_out2;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        valid;
    } id_ex_bundle_t;

    // A bubble must never write the register file or memory, nor redirect PC.
    function automatic id_ex_bundle_t bubble_bundle();
        id_ex_bundle_t b;
        b             = '0;
        b.reg_write   = NOREGWRITE;
        b.mem_write   = MEMWRITE_NONE;
        b.branch_type = NOBRANCH;
        b.alu_src2    = ALUSRC2_BUBBLE;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_ctrl_reg_sat_cnt16.sv
// 16-bit saturating event counter.
// Ports: clk, rst (async active-high), inc_i (count this edge), cnt_o (value).
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_ctrl_reg.sv
// ID/EX pipeline register with stall (en=0) and flush (clear=1) support.
// Ports: clk, rst (async active-high), en, clear; ID-stage bundle *D in;
// registered EX-stage copies *E out, ValidE, plus StallCnt / FlushCnt
// saturating event counters. All outputs come straight from flops.
module id_ex_ctrl_reg
    import id_ex_ctrl_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic        JalrD,
    input  logic [2:0]  RegWriteD,
    input  logic        MemToRegD,
    input  logic [3:0]  MemWriteD,
    input  logic        LoadNpcD,
    input  logic [1:0]  RegReadD,
    input  logic [2:0]  BranchTypeD,
    input  logic [3:0]  AluContrlD,
    input  logic        AluSrc1D,
    input  logic [1:0]  AluSrc2D,
    input  logic [31:0] PCD,
    input  logic [31:0] ImmD,
    input  logic [31:0] RegOut1D,
    input  logic [31:0] RegOut2D,
    input  logic [4:0]  RdD,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    output logic        JalrE,
    output logic [2:0]  RegWriteE,
    output logic        MemToRegE,
    output logic [3:0]  MemWriteE,
    output logic        LoadNpcE,
    output logic [1:0]  RegReadE,
    output logic [2:0]  BranchTypeE,
    output logic [3:0]  AluContrlE,
    output logic        AluSrc1E,
    output logic [1:0]  AluSrc2E,
    output logic [31:0] PCE,
    output logic [31:0] ImmE,
    output logic [31:0] RegOut1E,
    output logic [31:0] RegOut2E,
    output logic [4:0]  RdE,
    output logic [4:0]  A1E,
    output logic [4:0]  A2E,
    output logic        ValidE,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    id_ex_bundle_t bundle_q;
    id_ex_bundle_t bundle_d;
    id_ex_bundle_t bundle_in;

    always_comb begin
        bundle_in             = '0;
        bundle_in.jalr        = JalrD;
        bundle_in.reg_write   = RegWriteD;
        bundle_in.mem_to_reg  = MemToRegD;
        bundle_in.mem_write   = MemWriteD;
        bundle_in.load_npc    = LoadNpcD;
        bundle_in.reg_read    = RegReadD;
        bundle_in.branch_type = BranchTypeD;
        bundle_in.alu_contrl  = AluContrlD;
        bundle_in.alu_src1    = AluSrc1D;
        bundle_in.alu_src2    = AluSrc2D;
        bundle_in.pc          = PCD;
        bundle_in.imm         = ImmD;
        bundle_in.reg_out1    = RegOut1D;
        bundle_in.reg_out2    = RegOut2D;
        bundle_in.rd          = RdD;
        bundle_in.a1          = A1D;
        bundle_in.a2          = A2D;
        bundle_in.valid       = 1'b1;
    end

    // Flush wins over stall; stall wins over capture.
    always_comb begin
        bundle_d = bundle_q;
        if (clear) begin
            bundle_d = bubble_bundle();
        end else if (en) begin
            bundle_d = bundle_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= bubble_bundle();
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign JalrE       = bundle_q.jalr;
    assign RegWriteE   = bundle_q.reg_write;
    assign MemToRegE   = bundle_q.mem_to_reg;
    assign MemWriteE   = bundle_q.mem_write;
    assign LoadNpcE    = bundle_q.load_npc;
    assign RegReadE    = bundle_q.reg_read;
    assign BranchTypeE = bundle_q.branch_type;
    assign AluContrlE  = bundle_q.alu_contrl;
    assign AluSrc1E    = bundle_q.alu_src1;
    assign AluSrc2E    = bundle_q.alu_src2;
    assign PCE         = bundle_q.pc;
    assign ImmE        = bundle_q.imm;
    assign RegOut1E    = bundle_q.reg_out1;
    assign RegOut2E    = bundle_q.reg_out2;
    assign RdE         = bundle_q.rd;
    assign A1E         = bundle_q.a1;
    assign A2E         = bundle_q.a2;
    assign ValidE      = bundle_q.valid;

    // A flush edge counts only as a flush, never as a stall.
    sat_cnt16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (!clear && !en),
        .cnt_o (StallCnt)
    );

    sat_cnt16 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (clear),
        .cnt_o (FlushCnt)
    );

endmodule

// File: tb/tb_id_ex_ctrl_reg.sv
module tb_id_ex_ctrl_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        JalrD = 1'b0;
    logic [2:0]  RegWriteD = '0;
    logic        MemToRegD = 1'b0;
    logic [3:0]  MemWriteD = '0;
    logic        LoadNpcD = 1'b0;
    logic [1:0]  RegReadD = '0;
    logic [2:0]  BranchTypeD = '0;
    logic [3:0]  AluContrlD = '0;
    logic        AluSrc1D = 1'b0;
    logic [1:0]  AluSrc2D = '0;
    logic [31:0] PCD = '0, ImmD = '0, RegOut1D = '0, RegOut2D = '0;
    logic [4:0]  RdD = '0, A1D = '0, A2D = '0;

    logic        JalrE, MemToRegE, LoadNpcE, AluSrc1E, ValidE;
    logic [2:0]  RegWriteE, BranchTypeE;
    logic [3:0]  MemWriteE, AluContrlE;
    logic [1:0]  RegReadE, AluSrc2E;
    logic [31:0] PCE, ImmE, RegOut1E, RegOut2E;
    logic [4:0]  RdE, A1E, A2E;
    logic [15:0] StallCnt, FlushCnt;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: what the EX slot should hold (all outputs + valid,
    // zero meaning bubble) and the two event counts as plain integers.
    logic [165:0] exp_vec = '0;
    int           exp_stall = 0;
    int           exp_flush = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_reg dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .JalrD(JalrD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
        .MemWriteD(MemWriteD), .LoadNpcD(LoadNpcD), .RegReadD(RegReadD),
        .BranchTypeD(BranchTypeD), .AluContrlD(AluContrlD),
        .AluSrc1D(AluSrc1D), .AluSrc2D(AluSrc2D), .PCD(PCD), .ImmD(ImmD),
        .RegOut1D(RegOut1D), .RegOut2D(RegOut2D), .RdD(RdD), .A1D(A1D),
        .A2D(A2D),
        .JalrE(JalrE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .MemWriteE(MemWriteE), .LoadNpcE(LoadNpcE), .RegReadE(RegReadE),
        .BranchTypeE(BranchTypeE), .AluContrlE(AluContrlE),
        .AluSrc1E(AluSrc1E), .AluSrc2E(AluSrc2E), .PCE(PCE), .ImmE(ImmE),
        .RegOut1E(RegOut1E), .RegOut2E(RegOut2E), .RdE(RdE), .A1E(A1E),
        .A2E(A2E), .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    function automatic logic [164:0] d_vec();
        return {JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD,
                BranchTypeD, AluContrlD, AluSrc1D, AluSrc2D, PCD, ImmD,
                RegOut1D, RegOut2D, RdD, A1D, A2D};
    endfunction

    function automatic logic [165:0] obs_vec();
        return {JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE,
                BranchTypeE, AluContrlE, AluSrc1E, AluSrc2E, PCE, ImmE,
                RegOut1E, RegOut2E, RdE, A1E, A2E, ValidE};
    endfunction

    task automatic randomize_d();
        JalrD = 1'($urandom);       RegWriteD = 3'($urandom);
        MemToRegD = 1'($urandom);   MemWriteD = 4'($urandom);
        LoadNpcD = 1'($urandom);    RegReadD = 2'($urandom);
        BranchTypeD = 3'($urandom); AluContrlD = 4'($urandom);
        AluSrc1D = 1'($urandom);    AluSrc2D = 2'($urandom);
        PCD = $urandom; ImmD = $urandom; RegOut1D = $urandom; RegOut2D = $urandom;
        RdD = 5'($urandom); A1D = 5'($urandom); A2D = 5'($urandom);
    endtask

    // One rising edge with rst low; the model applies the priority rules,
    // then outputs are left to settle before sampling.
    task automatic step();
        @(posedge clk);
        if (clear) begin
            exp_vec = '0;
            if (exp_flush < 65535) exp_flush++;
        end else if (en) begin
            exp_vec = {d_vec(), 1'b1};
        end else begin
            if (exp_stall < 65535) exp_stall++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_vec = '0;
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic check_all(input string name);
        n_total++;
        if (obs_vec() !== exp_vec)
            $display("FAIL %s bundle: got %h expected %h", name, obs_vec(), exp_vec);
        else n_pass++;
        n_total++;
        if (StallCnt !== 16'(exp_stall))
            $display("FAIL %s StallCnt: got %0d expected %0d", name, StallCnt, exp_stall);
        else n_pass++;
        n_total++;
        if (FlushCnt !== 16'(exp_flush))
            $display("FAIL %s FlushCnt: got %0d expected %0d", name, FlushCnt, exp_flush);
        else n_pass++;
    endtask

    task automatic test_reset();
        randomize_d();
        en = 1'b1;
        clear = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (obs_vec() !== '0 || StallCnt !== 16'd0 || FlushCnt !== 16'd0)
            $display("FAIL reset_state: got %h/%0d/%0d expected 0/0/0",
                     obs_vec(), StallCnt, FlushCnt);
        else n_pass++;
        do_reset();
        check_all("reset_release");
    endtask

    task automatic test_capture();
        randomize_d();
        en = 1'b1; clear = 1'b0;
        RegWriteD = 3'd3; MemWriteD = 4'b1111; PCD = 32'h0000_1000;
        step();
        n_total++;
        if (RegWriteE !== 3'd3 || MemWriteE !== 4'b1111 || PCE !== 32'h0000_1000 || ValidE !== 1'b1)
            $display("FAIL capture: got rw=%0d mw=%b pc=%h v=%b expected rw=3 mw=1111 pc=00001000 v=1",
                     RegWriteE, MemWriteE, PCE, ValidE);
        else n_pass++;
        check_all("capture");
    endtask

    task automatic test_stall();
        do_reset();
        randomize_d();
        en = 1'b1; clear = 1'b0; PCD = 32'h10;
        step();
        en = 1'b0; PCD = 32'h14;
        repeat (3) step();
        n_total++;
        if (PCE !== 32'h10 || StallCnt !== 16'd3)
            $display("FAIL stall: got pc=%h cnt=%0d expected pc=00000010 cnt=3", PCE, StallCnt);
        else n_pass++;
        check_all("stall");
    endtask

    task automatic test_flush();
        int s0;
        int f0;
        s0 = exp_stall;
        f0 = exp_flush;
        en = 1'b0; clear = 1'b1; RegWriteD = 3'd3;
        step();
        n_total++;
        if (RegWriteE !== 3'd0 || MemWriteE !== 4'b0000 || BranchTypeE !== 3'd0 || ValidE !== 1'b0)
            $display("FAIL flush_bubble: got rw=%0d mw=%b bt=%0d v=%b expected 0 0000 0 0",
                     RegWriteE, MemWriteE, BranchTypeE, ValidE);
        else n_pass++;
        n_total++;
        if (FlushCnt !== 16'(f0 + 1) || StallCnt !== 16'(s0))
            $display("FAIL flush_counts: got f=%0d s=%0d expected f=%0d s=%0d",
                     FlushCnt, StallCnt, f0 + 1, s0);
        else n_pass++;
        clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [165:0] a_vec;
        logic [165:0] b_vec;
        randomize_d();
        en = 1'b1; clear = 1'b0;
        a_vec = {d_vec(), 1'b1};
        step();
        n_total++;
        if (obs_vec() !== a_vec) $display("FAIL b2b_A: got %h expected %h", obs_vec(), a_vec);
        else n_pass++;
        randomize_d();
        clear = 1'b1;
        step();
        n_total++;
        if (obs_vec() !== '0) $display("FAIL b2b_bubble: got %h expected 0", obs_vec());
        else n_pass++;
        randomize_d();
        clear = 1'b0;
        b_vec = {d_vec(), 1'b1};
        step();
        n_total++;
        if (obs_vec() !== b_vec) $display("FAIL b2b_B: got %h expected %h", obs_vec(), b_vec);
        else n_pass++;
        check_all("b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            randomize_d();
            en = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 5) == 0);
            step();
            check_all("random");
        end
        clear = 1'b0;
    endtask

    task automatic test_async_reset();
        randomize_d();
        en = 1'b1; clear = 1'b0; MemWriteD = 4'b0011;
        step();
        n_total++;
        if (MemWriteE !== 4'b0011) $display("FAIL areset_pre: got %b expected 0011", MemWriteE);
        else n_pass++;
        en = 1'b0;
        #3;
        rst = 1'b1;
        exp_vec = '0; exp_stall = 0; exp_flush = 0;
        #1;
        n_total++;
        if (MemWriteE !== 4'b0000 || ValidE !== 1'b0 || StallCnt !== 16'd0 || FlushCnt !== 16'd0)
            $display("FAIL areset: got mw=%b v=%b s=%0d f=%0d expected 0000 0 0 0",
                     MemWriteE, ValidE, StallCnt, FlushCnt);
        else n_pass++;
        check_all("areset");
        #1;
        rst = 1'b0;
        step();
        check_all("areset_resume_stall");
        randomize_d();
        en = 1'b1;
        step();
        check_all("areset_resume_capture");
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b0; clear = 1'b0;
        repeat (65540) step();
        n_total++;
        if (StallCnt !== 16'hFFFF) $display("FAIL saturation: got %h expected ffff", StallCnt);
        else n_pass++;
        check_all("saturation");
        repeat (3) step();
        n_total++;
        if (StallCnt !== 16'hFFFF) $display("FAIL saturation_hold: got %h expected ffff", StallCnt);
        else n_pass++;
        check_all("saturation_hold");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_reg.md
ID_EX_CTRL_REG -- requirements
Module: id_ex_ctrl_reg

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port en  input  1  1 = capture ID bundle; 0 = hold (stall).
REQ-004 SHALL have port clear  input  1  1 = load bubble (flush).
REQ-005 SHALL have ports JalrD 1, RegWriteD 3, MemToRegD 1, MemWriteD 4, LoadNpcD 1, RegReadD 2, BranchTypeD 3, AluContrlD 4, AluSrc1D 1, AluSrc2D 2  input  ID-stage control bundle from decoder.
REQ-006 SHALL have ports PCD 32, ImmD 32, RegOut1D 32, RegOut2D 32, RdD 5, A1D 5, A2D 5  input  ID-stage datapath bundle.
REQ-007 SHALL have ports with identical widths and suffix E (JalrE ... A2E)  output  registered EX-stage copies.
REQ-008 SHALL have port ValidE  output  1  1 = EX slot holds a real instruction.
REQ-009 SHALL have ports StallCnt, FlushCnt  output  16 each  saturating event counters.

Function
REQ-010 SHALL apply per-edge priority: rst > clear > !en > capture.
REQ-011 SHALL, on capture (clear=0, en=1), load every E output from its D input and set ValidE=1, one-cycle latency.
REQ-012 SHALL, on hold (clear=0, en=0), keep all E outputs and ValidE unchanged.
REQ-013 SHALL, on clear=1 (regardless of en), load bubble: RegWriteE=NOREGWRITE(0), MemWriteE=0000, BranchTypeE=NOBRANCH(0), JalrE=0, LoadNpcE=0, MemToRegE=0, RegReadE=00, AluContrlE=0, AluSrc1E=0, AluSrc2E=00, all data/index outputs 0, ValidE=0.
REQ-014 SHALL guarantee a bubble never writes register file or memory and never redirects PC.
REQ-015 SHALL increment StallCnt by 1 on each edge with clear=0 and en=0.
REQ-016 SHALL increment FlushCnt by 1 on each edge with clear=1 (including clear with en=0; StallCnt then unchanged).
REQ-017 SHALL saturate both counters at 16'hFFFF (no wrap).
REQ-018 SHALL capture D inputs verbatim, including undecoded AluContrlD values; no re-encoding.
REQ-019 SHALL contain no combinational path from any input to any output.

Reset
REQ-020 SHALL, while rst=1, force all outputs to the bubble values of REQ-013 and StallCnt=FlushCnt=0, immediately (asynchronously).
REQ-021 SHALL, on rst deassertion, resume normal REQ-010 behaviour at the next rising edge; rst mid-stall or mid-flush discards the held bundle.

Structure
REQ-022 SHALL take NOREGWRITE, NOBRANCH, RegWrite/BranchType/ALUContrl encodings from the shared Parameters.v definitions; no local redefinition.
REQ-023 SHALL place bubble constants (MemWrite 0000, AluSrc2 00) in the shared parameters file for reuse by the EX/MEM register.
REQ-024 SHALL be one module with one natural sub-module: sat_cnt16 (16-bit saturating counter, inc input), instantiated twice.

Verification
REQ-025 SHALL verify capture: en=1, clear=0, RegWriteD=3, MemWriteD=1111, PCD=32'h0000_1000 -> next edge RegWriteE=3, MemWriteE=1111, PCE=32'h0000_1000, ValidE=1.
REQ-026 SHALL verify stall: capture PCD=32'h10, then en=0 for 3 cycles with PCD=32'h14 -> PCE stays 32'h10, StallCnt=3.
REQ-027 SHALL verify flush priority: en=0, clear=1, RegWriteD=3 -> RegWriteE=0, MemWriteE=0000, BranchTypeE=0, ValidE=0, FlushCnt+1, StallCnt unchanged.
REQ-028 SHALL verify saturation: hold en=0 for 65540 cycles -> StallCnt=16'hFFFF, stays.
REQ-029 SHALL verify async reset: assert rst mid-cycle after capture with MemWriteE=0011 -> MemWriteE=0000, ValidE=0, counters 0 before next edge.
REQ-030 SHALL verify back-to-back: capture A, clear, capture B on consecutive edges -> outputs A, bubble, B in order.
